sprite_loader: RTL and testbench

Streaming writer for sprite memory: accepts 16-bit pixel words over a valid/ready handshake and writes them row-major into a sprite RAM region of `width × height` starting at a base address. It is the write-side counterpart of the per-pixel sprite ROM read path. It sits between an external pixel source (UART/host bridge) and the write port of the dual-port sprite RAM whose read port the renderer uses.

---
 rtl/sprite_loader_pkg.sv | 25 ++
 rtl/sprite_rect_counter.sv | 64 ++++++
 rtl/sprite_loader.sv | 162 ++++++++++++++++
 tb/tb_sprite_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sprite_loader_pkg                                             |
// | Purpose  : Shared definitions for the sprite memory read and write paths:|
// |            memory geometry defaults, pixel type and loader FSM states.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package sprite_loader_pkg;

   localparam int SPRITE_DATA_W = 16;     // RGB565 pixel word
   localparam int SPRITE_DEPTH  = 24000;  // sprite memory entries
   localparam int SPRITE_ADDR_W = 15;     // 2**15 >= 24000
   localparam int RECT_DIM_W    = 10;     // width/height field width

   typedef logic [15:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_rect_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sprite_rect_counter                                           |
// | Purpose  : Row-major x/y/address walker over a width x height rectangle. |
// |            Latches geometry on init, steps on advance, flags the last    |
// |            pixel of the rectangle.                                       |
// | Ports    : clk, rst (async, active-high), init, advance, base_addr,      |
// |            sprite_width, sprite_height -> addr, last                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sprite_rect_counter
   import sprite_loader_pkg::*;
#(
   parameter int ADDR_W = SPRITE_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic                  advance,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [RECT_DIM_W-1:0] sprite_width,
   input  logic [RECT_DIM_W-1:0] sprite_height,
   output logic [ADDR_W-1:0]     addr,
   output logic                  last
);

   logic [RECT_DIM_W-1:0] r_w;
   logic [RECT_DIM_W-1:0] r_h;
   logic [RECT_DIM_W-1:0] r_x;
   logic [RECT_DIM_W-1:0] r_y;
   logic [ADDR_W-1:0]     r_addr;
   logic                  w_x_wrap;

   // Geometry is guaranteed non-zero by the caller, so w-1 / h-1 never wrap.
   assign w_x_wrap = (r_x == r_w - 10'd1);
   assign last     = w_x_wrap && (r_y == r_h - 10'd1);
   assign addr     = r_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w    <= '0;
         r_h    <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (init) begin
         r_w    <= sprite_width;
         r_h    <= sprite_height;
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= base_addr;
      end else if (advance) begin
         r_addr <= r_addr + 1'b1;
         if (w_x_wrap) begin
            r_x <= '0;
            r_y <= r_y + 10'd1;
         end else begin
            r_x <= r_x + 10'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sprite_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sprite_loader                                                 |
// | Purpose  : Streams pixel words (valid/ready) into a rectangular region   |
// |            of sprite RAM, row-major from base_addr, one write per cycle. |
// | Ports    : clk, rst (async, active-high), start, abort, base_addr,       |
// |            sprite_width, sprite_height, in_valid, in_data -> in_ready,   |
// |            wr_en, wr_addr, wr_data, busy, done, error                    |
// | Config   : SPRITE_LOADER_COLORKEY_EN - words equal to COLOR_KEY are      |
// |            consumed but not written.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sprite_loader
   import sprite_loader_pkg::*;
#(
   parameter int                DATA_W    = SPRITE_DATA_W,
   parameter int                DEPTH     = SPRITE_DEPTH,
   parameter int                ADDR_W    = SPRITE_ADDR_W,
   parameter logic [DATA_W-1:0] COLOR_KEY = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [RECT_DIM_W-1:0] sprite_width,
   input  logic [RECT_DIM_W-1:0] sprite_height,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

`ifdef SPRITE_LOADER_COLORKEY_EN
   localparam logic c_key_en = 1'b1;
`else
   localparam logic c_key_en = 1'b0;
`endif

   loader_state_t     r_state;
   loader_state_t     w_next_state;

   logic [19:0]       w_prod;
   logic [20:0]       w_end;
   logic              w_illegal;
   logic              w_req;
   logic              w_accept;
   logic              w_xfer;
   logic              w_keyed;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_error;

   // Full-width bounds check: 10x10 product is 20 bits, end address 21 bits.
   assign w_prod    = 20'(sprite_width) * 20'(sprite_height);
   assign w_end     = 21'(base_addr) + 21'(w_prod);
   assign w_illegal = (sprite_width == '0) || (sprite_height == '0) ||
                      (w_end > 21'(DEPTH));

   assign w_req    = (r_state == ST_IDLE) && start;
   assign w_accept = w_req && !w_illegal;

   // A word offered in the same cycle as abort is dropped with the load.
   assign w_xfer   = (r_state == ST_LOAD) && in_valid && in_ready && !abort;
   assign w_keyed  = c_key_en && (in_data == COLOR_KEY);

   sprite_rect_counter #(
      .ADDR_W (ADDR_W)
   ) u_rect_counter (
      .clk           (clk),
      .rst           (rst),
      .init          (w_accept),
      .advance       (w_xfer),
      .base_addr     (base_addr),
      .sprite_width  (sprite_width),
      .sprite_height (sprite_height),
      .addr          (w_addr),
      .last          (w_last)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort)                w_next_state = ST_IDLE;
            else if (w_xfer && w_last) w_next_state = ST_FLUSH;
         end
         ST_FLUSH: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode (from the state register only)
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_FLUSH: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Write port and error pulse, one cycle behind the accepting edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_error   <= 1'b0;
      end else begin
         r_wr_en <= w_xfer && !w_keyed;
         r_error <= w_req && w_illegal;
         if (w_xfer) begin
            r_wr_addr <= w_addr;
            r_wr_data <= in_data;
         end
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sprite_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sprite_loader                                              |
// | Purpose  : Directed self-checking bench for sprite_loader.               |
// | Ports    : none                                                          |
// | Config   : SPRITE_LOADER_COLORKEY_EN selects the keyed expectations.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sprite_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [14:0] base_addr;
   logic [9:0]  sprite_width;
   logic [9:0]  sprite_height;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;

   int n_vec = 0;
   int n_err = 0;

   // Observation log, written only by the monitor
   int q_addr[$];
   int q_data[$];
   int done_cnt = 0;
   int err_cnt = 0;
   int busy_cnt = 0;
   int done_at_wr = -1;
   logic done_wr_en = 1'b0;
   logic busy_after_done = 1'b1;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   sprite_loader #(
      .DATA_W    (16),
      .DEPTH     (24000),
      .ADDR_W    (15),
      .COLOR_KEY (16'h0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .base_addr     (base_addr),
      .sprite_width  (sprite_width),
      .sprite_height (sprite_height),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always @(negedge clk) begin
      if (wr_en) begin
         q_addr.push_back(int'(wr_addr));
         q_data.push_back(int'(wr_data));
      end
      if (done) begin
         done_cnt++;
         done_at_wr = q_addr.size();
         done_wr_en = wr_en;
      end
      if (error) err_cnt++;
      if (busy)  busy_cnt++;
      if (prev_done) busy_after_done = busy;
      prev_done = done;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int base, input int w, input int h);
      base_addr     = 15'(base);
      sprite_width  = 10'(w);
      sprite_height = 10'(h);
      start         = 1'b1;
      tick();
      start         = 1'b0;
   endtask

   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = 16'(d);
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Check n writes starting at log index q0: addresses a0.., data d0..
   task automatic verify(input string tag, input int q0, input int n,
                         input int a0, input int d0);
      chk({tag, "_count"}, 32'(q_addr.size() - q0), 32'(n));
      for (int i = 0; i < n && (q0 + i) < q_addr.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[q0+i]), 32'(a0 + i));
         chk($sformatf("%s_data%0d", tag, i), 32'(q_data[q0+i]), 32'(d0 + i));
      end
   endtask

   initial begin
      int q0;
      int d0;
      int e0;
      int b0;

      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      base_addr = '0; sprite_width = '0; sprite_height = '0;
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en",    32'(wr_en),    32'd0);
      chk("rst_wr_addr",  32'(wr_addr),  32'd0);
      chk("rst_wr_data",  32'(wr_data),  32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_error",    32'(error),    32'd0);
      rst = 1'b0;
      tick();

      // 1: 3x2 at 100, back-to-back words 1..6
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(100, 3, 2);
      chk("t1_busy_after_start", 32'(busy), 32'd1);
      for (int k = 1; k <= 6; k++) send(k);
      tick(); tick(); tick();
      verify("t1", q0, 6, 100, 1);
      chk("t1_done_cnt",   32'(done_cnt - d0), 32'd1);
      chk("t1_done_on_wr", 32'(done_wr_en), 32'd1);
      chk("t1_done_at_6",  32'(done_at_wr - q0), 32'd6);
      chk("t1_busy_after", 32'(busy_after_done), 32'd0);

      // 2: same load with a 4-cycle valid gap after the 2nd word
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(100, 3, 2);
      send(1); send(2);
      for (int k = 0; k < 4; k++) tick();
      for (int k = 3; k <= 6; k++) send(k);
      tick(); tick(); tick();
      verify("t2", q0, 6, 100, 1);
      chk("t2_done_cnt",  32'(done_cnt - d0), 32'd1);
      chk("t2_done_at_6", 32'(done_at_wr - q0), 32'd6);

      // 3: illegal requests and the exact-fit boundary
      q0 = q_addr.size(); e0 = err_cnt; b0 = busy_cnt; d0 = done_cnt;
      start_load(23990, 5, 3);
      tick(); tick();
      chk("t3_oob_err",    32'(err_cnt - e0), 32'd1);
      chk("t3_oob_nowr",   32'(q_addr.size() - q0), 32'd0);
      chk("t3_oob_nobusy", 32'(busy_cnt - b0), 32'd0);
      start_load(100, 0, 2);
      tick();
      chk("t3_w0_err", 32'(err_cnt - e0), 32'd2);
      start_load(100, 4, 0);
      tick();
      chk("t3_h0_err", 32'(err_cnt - e0), 32'd3);
      start_load(23994, 3, 2);
      chk("t3_fit_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_fit_abort_busy", 32'(busy), 32'd0);
      tick();
      chk("t3_fit_noerr",  32'(err_cnt - e0), 32'd3);
      chk("t3_fit_nodone", 32'(done_cnt - d0), 32'd0);

      // 4: 10x1 aborted after 4 transfers, then a clean 2x2
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(100, 10, 1);
      for (int k = 0; k < 4; k++) send(16'h11 + k);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick(); tick();
      verify("t4_abort", q0, 4, 100, 16'h11);
      chk("t4_nodone", 32'(done_cnt - d0), 32'd0);
      chk("t4_idle",   32'(busy), 32'd0);
      q0 = q_addr.size();
      start_load(200, 2, 2);
      for (int k = 0; k < 4; k++) send(16'hA0 + k);
      tick(); tick(); tick();
      verify("t4_after", q0, 4, 200, 16'hA0);
      chk("t4_after_done", 32'(done_cnt - d0), 32'd1);

      // 5: asynchronous reset in the middle of a load
      start_load(100, 3, 2);
      send(16'h21); send(16'h22);
      rst = 1'b1;
      #1;
      chk("t5_in_ready", 32'(in_ready), 32'd0);
      chk("t5_wr_en",    32'(wr_en),    32'd0);
      chk("t5_wr_addr",  32'(wr_addr),  32'd0);
      chk("t5_wr_data",  32'(wr_data),  32'd0);
      chk("t5_busy",     32'(busy),     32'd0);
      tick();
      rst = 1'b0;
      tick();
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(5, 1, 1);
      send(16'h77);
      tick(); tick();
      verify("t5_after", q0, 1, 5, 16'h77);
      chk("t5_after_done", 32'(done_cnt - d0), 32'd1);

      // 6: 3x1 at 0 with words 5,0,7
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(0, 3, 1);
      send(5); send(0); send(7);
      tick(); tick(); tick();
`ifdef SPRITE_LOADER_COLORKEY_EN
      chk("t6_count", 32'(q_addr.size() - q0), 32'd2);
      if (q_addr.size() - q0 >= 2) begin
         chk("t6_addr0", 32'(q_addr[q0]),   32'd0);
         chk("t6_data0", 32'(q_data[q0]),   32'd5);
         chk("t6_addr1", 32'(q_addr[q0+1]), 32'd2);
         chk("t6_data1", 32'(q_data[q0+1]), 32'd7);
      end
      chk("t6_done", 32'(done_cnt - d0), 32'd1);
      // keyed last pixel: done still pulses, without a write
      q0 = q_addr.size(); d0 = done_cnt;
      start_load(9, 1, 1);
      send(0);
      tick(); tick();
      chk("t6k_nowr",    32'(q_addr.size() - q0), 32'd0);
      chk("t6k_done",    32'(done_cnt - d0), 32'd1);
      chk("t6k_done_we", 32'(done_wr_en), 32'd0);
`else
      chk("t6_count", 32'(q_addr.size() - q0), 32'd3);
      if (q_addr.size() - q0 >= 3) begin
         chk("t6_addr1", 32'(q_addr[q0+1]), 32'd1);
         chk("t6_data0", 32'(q_data[q0]),   32'd5);
         chk("t6_data1", 32'(q_data[q0+1]), 32'd0);
         chk("t6_data2", 32'(q_data[q0+2]), 32'd7);
      end
      chk("t6_done", 32'(done_cnt - d0), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
